// File: rtl/apb4_master_bridge.sv
// APB4 initiator: one valid/ready command becomes one SETUP/ACCESS transfer, and
// read data, slverr and the wait-state watchdog result come back on a valid/ready response.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TMO_WIDTH  = 8
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    input  logic [TMO_WIDTH-1:0]    tmo_cyc_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    resp_tmo_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state, state_nxt;
    logic [TMO_WIDTH-1:0] wdog, wdog_inc;
    logic                 abort;

    // Saturating increment: a long stall must never wrap back below the limit.
    assign wdog_inc = (wdog == {TMO_WIDTH{1'b1}}) ? wdog : wdog + TMO_WIDTH'(1);
    // pready in the same cycle as the limit is reached wins over the abort.
    assign abort = (state == ACCESS) && !pready_i && (tmo_cyc_i != '0) && (wdog_inc >= tmo_cyc_i);

    assign req_ready_o  = (state == IDLE);
    assign psel_o       = (state == SETUP) || (state == ACCESS);
    assign penable_o    = (state == ACCESS);
    assign resp_valid_o = (state == RESP);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid_i)        state_nxt = SETUP;
            SETUP:                           state_nxt = ACCESS;
            ACCESS:  if (pready_i || abort)  state_nxt = RESP;
            RESP:    if (resp_ready_i)       state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr_o      <= '0;
            pprot_o      <= '0;
            pwrite_o     <= 1'b0;
            pwdata_o     <= '0;
            pstrb_o      <= '0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            resp_tmo_o   <= 1'b0;
            wdog         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    paddr_o  <= req_addr_i;
                    pprot_o  <= req_prot_i;
                    pwrite_o <= req_write_i;
                    pwdata_o <= req_write_i ? req_wdata_i : '0;
                    pstrb_o  <= req_write_i ? req_strb_i  : '0;
                    wdog     <= '0;
                end
                ACCESS: begin
                    if (pready_i) begin
                        resp_rdata_o <= pwrite_o ? '0 : prdata_i;
                        resp_err_o   <= pslverr_i;
                        resp_tmo_o   <= 1'b0;
                    end else if (abort) begin
                        resp_rdata_o <= '0;
                        resp_err_o   <= 1'b1;
                        resp_tmo_o   <= 1'b1;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Randomized scoreboard bench for apb4_master_bridge: a slave model drives planned wait
// states, the expected response of each request is queued and checked by a monitor.
module tb_apb4_master_bridge;
    logic        pclk = 0, presetn = 0;
    logic        req_valid = 0, req_ready, req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_strb = 0;
    logic [2:0]  req_prot = 0;
    logic [7:0]  tmo_cyc = 0;
    logic        resp_valid, resp_ready = 0, resp_err, resp_tmo;
    logic [31:0] resp_rdata;
    logic [31:0] paddr, pwdata, prdata = 0;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic        psel, penable, pwrite, pready = 0, pslverr = 0;

    apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TMO_WIDTH(8)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .req_prot_i(req_prot), .tmo_cyc_i(tmo_cyc),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .resp_tmo_o(resp_tmo),
        .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
        .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
        int w; logic err; logic [31:0] rdata;
    } plan_t;
    typedef struct { logic [31:0] rdata; logic err; logic tmo; int lat; } exp_t;

    plan_t slave_q[$];
    exp_t  exp_q[$];
    int    acc_q[$];
    int    checks = 0, errors = 0, cyc = 0, stall_cycles = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Reference: the slave raises pready after w wait states; the watchdog wins only
    // if tmo ACCESS cycles pass with pready low, i.e. w >= tmo.
    function automatic exp_t model(input plan_t p, input int tmo);
        exp_t e;
        bit to = (tmo != 0) && (p.w >= tmo);
        e.tmo   = to;
        e.err   = to ? 1'b1 : p.err;
        e.rdata = (to || p.wr) ? 32'h0 : p.rdata;
        e.lat   = to ? 2 + tmo : 3 + p.w;
        return e;
    endfunction

    // mode 0: no response expected, 1: model response, 2: caller pushes the expectation
    task automatic issue(input plan_t p, input int tmo, input int mode);
        int n = 0;
        @(negedge pclk);
        while (!req_ready && n < 5000) begin @(negedge pclk); n++; end
        if (n >= 5000) begin
            errors++; $display("FAIL req_ready_wait: got 0 expected 1"); return;
        end
        tmo_cyc   = 8'(tmo);
        req_write = p.wr; req_addr = p.addr; req_wdata = p.wdata;
        req_strb  = p.strb; req_prot = p.prot; req_valid = 1;
        slave_q.push_back(p);
        if (mode != 0) acc_q.push_back(cyc);
        if (mode == 1) exp_q.push_back(model(p, tmo));
        @(posedge pclk); #1;
        req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
    endtask

    function automatic plan_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int w, input logic e,
                                 input logic [31:0] rd);
        plan_t p;
        p.wr = wr; p.addr = a; p.wdata = d; p.strb = s; p.prot = 3'($urandom);
        p.w = w; p.err = e; p.rdata = rd;
        return p;
    endfunction

    // Slave model: checks the registered request fields every psel cycle.
    initial begin
        plan_t cur;
        int acc = 0;
        bit have = 0;
        forever begin
            @(negedge pclk);
            if (psel && !penable) begin
                if (slave_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_setup: got psel expected none");
                end else begin cur = slave_q.pop_front(); have = 1; end
                acc = 0;
            end
            if (psel && have) begin
                chk("paddr",  paddr,  cur.addr);
                chk("pwrite", pwrite, cur.wr);
                chk("pprot",  pprot,  cur.prot);
                chk("pwdata", pwdata, cur.wr ? cur.wdata : 32'h0);
                chk("pstrb",  pstrb,  cur.wr ? cur.strb : 4'h0);
            end
            if (psel && penable) begin
                acc++;
                if (acc == cur.w + 1) begin
                    pready = 1; prdata = cur.rdata; pslverr = cur.err;
                end else begin
                    pready = 0; prdata = $urandom; pslverr = 1'($urandom);
                end
            end else begin
                pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        exp_t e;
        bit prev_v = 0, hold = 0, hs_pend = 0, rr;
        logic [31:0] s_rdata;
        logic s_err, s_tmo;
        int a;
        forever begin
            @(negedge pclk);
            if (!presetn) begin prev_v = 0; hold = 0; hs_pend = 0; continue; end
            if (hs_pend) begin
                chk("req_ready_after_hs", req_ready, 1'b1);
                chk("resp_valid_after_hs", resp_valid, 1'b0);
                hs_pend = 0;
            end
            if (resp_valid) begin
                chk("psel_in_resp", psel, 1'b0);
                chk("req_ready_in_resp", req_ready, 1'b0);
                if (hold) begin
                    chk("rdata_stable", resp_rdata, s_rdata);
                    chk("err_stable", resp_err, s_err);
                    chk("tmo_stable", resp_tmo, s_tmo);
                end
                if (!prev_v) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        errors++; $display("FAIL unexpected_resp: got resp_valid expected none");
                    end else begin
                        a = acc_q.pop_front();
                        chk("latency", 64'(cyc - a), 64'(exp_q[0].lat));
                    end
                end
                if (stall_cycles > 0) begin rr = 0; stall_cycles--; end
                else rr = ($urandom_range(0, 2) != 0);
                resp_ready = rr;
                if (rr) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", resp_err, e.err);
                        chk("resp_tmo", resp_tmo, e.tmo);
                    end
                    hs_pend = 1; hold = 0;
                end else begin
                    hold = 1; s_rdata = resp_rdata; s_err = resp_err; s_tmo = resp_tmo;
                end
            end else begin
                resp_ready = 1'($urandom); hold = 0;
            end
            prev_v = resp_valid;
        end
    end

    initial begin
        plan_t p;
        exp_t  e;
        int    n;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb", pstrb, 4'h0);
        chk("rst_resp", {resp_rdata, resp_err, resp_tmo}, 34'h0);
        @(negedge pclk); presetn = 1;

        issue(mk(1, 32'h4, 32'hA5A5_0001, 4'hF, 0, 0, 0), 0, 1);
        issue(mk(0, 32'h10, 32'h0, 4'h0, 3, 0, 32'h1234), 0, 1);
        issue(mk(1, 32'h20, 32'hDEAD_BEEF, 4'h3, 1, 1, 0), 0, 1);
        issue(mk(0, 32'h24, 32'h0, 4'h0, 2, 1, 32'hCAFE_0001), 0, 1);
        issue(mk(0, 32'h30, 32'h0, 4'h0, 10, 0, 32'h5555), 5, 1);
        issue(mk(0, 32'h34, 32'h0, 4'h0, 4, 0, 32'h6666), 5, 1);
        stall_cycles = 10;
        issue(mk(1, 32'h40, 32'h1111_2222, 4'hC, 0, 0, 0), 0, 1);

        // Reset pulse in the middle of a hung ACCESS: no response may follow.
        issue(mk(1, 32'h50, 32'h7777_7777, 4'hF, 1000, 0, 0), 0, 0);
        repeat (5) @(negedge pclk);
        #2 presetn = 0;
        #1;
        chk("midrst_psel", psel, 1'b0);
        chk("midrst_penable", penable, 1'b0);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_paddr", paddr, 32'h0);
        @(negedge pclk); presetn = 1;
        issue(mk(0, 32'h54, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D), 0, 1);

        // Watchdog saturation: 299 low cycles with the watchdog off, then limit 255.
        issue(mk(0, 32'h60, 32'h0, 4'h0, 100000, 0, 32'h1), 0, 2);
        e.rdata = 0; e.err = 1; e.tmo = 1; e.lat = 302;
        exp_q.push_back(e);
        repeat (301) @(negedge pclk);
        tmo_cyc = 8'd255;

        for (int i = 0; i < 150; i++) begin
            p = mk(1'($urandom), $urandom & 32'hFFFC, $urandom, 4'($urandom),
                   $urandom_range(0, 8), 1'($urandom_range(0, 3) == 0), $urandom);
            issue(p, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6), 1);
            repeat ($urandom_range(0, 3)) @(negedge pclk);
        end

        n = 0;
        while ((exp_q.size() != 0 || slave_q.size() != 0) && n < 2000) begin @(negedge pclk); n++; end
        if (n >= 2000) begin
            errors++; $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
